// File: rtl/uart_echo_fifo.sv
// Buffered echo between uart_rx and uart_tx: received bytes are case-transformed into a
// circular FIFO and replayed to the transmitter through a start/busy handshake FSM.
module uart_echo_fifo #(
   parameter int unsigned DW    = 8,
   parameter int unsigned AW    = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_rcv,
   input  logic [DW-1:0]    rx_data,
   input  logic             tx_ready,
   output logic             tx_start,
   output logic [DW-1:0]    tx_data,
   input  logic [1:0]       mode,
   input  logic             ovf_clr,
   output logic [3:0]       leds,
   output logic             ovf,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [AW:0]      level
);

   localparam int unsigned DEPTH = 2**AW;
   localparam logic [1:0]  MODE_UPPER = 2'b01;
   localparam logic [1:0]  MODE_LOWER = 2'b10;
   localparam logic [1:0]  MODE_MUTE  = 2'b11;

   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic [1:0]    wait_cnt;
   logic          full_c, accept_c, push_c, drop_c, pop_c, start_nxt;

   // Case folding only makes sense for 8-bit ASCII characters
   function automatic logic [DW-1:0] xform(input logic [DW-1:0] d, input logic [1:0] m);
      logic [DW-1:0] r;
      r = d;
      if (DW == 8) begin
         if (m == MODE_UPPER && d >= DW'(8'h61) && d <= DW'(8'h7A))
            r = d - DW'(8'h20);
         else if (m == MODE_LOWER && d >= DW'(8'h41) && d <= DW'(8'h5A))
            r = d + DW'(8'h20);
      end
      return r;
   endfunction

   assign full_c   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign accept_c = rx_rcv && (mode != MODE_MUTE);
   assign push_c   = accept_c && !full_c;
   assign drop_c   = accept_c && full_c;

   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr[AW-1:0]] <= xform(rx_data, mode);
   end

   // Pointers and occupancy; a push on full is refused even if a pop frees a slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop_c)  rd_ptr <= rd_ptr + (AW+1)'(1);
         level <= level + (AW+1)'(push_c) - (AW+1)'(pop_c);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         leds     <= '0;
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (rx_rcv) leds <= rx_data[3:0];
         if (ovf_clr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
         end else if (drop_c) begin
            ovf <= 1'b1;
            if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (level != '0 && tx_ready) state_nxt = START;
         START:     state_nxt = WAIT_BUSY;
         WAIT_BUSY: if (!tx_ready)               state_nxt = WAIT_DONE;
                    else if (wait_cnt == 2'd3)   state_nxt = IDLE;
         WAIT_DONE: if (tx_ready)                state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pop_c     = 1'b0;
      start_nxt = 1'b0;
      if (state == IDLE && level != '0 && tx_ready) pop_c = 1'b1;
      if (state == START) start_nxt = 1'b1;
   end

   // Timeout counter for a transmitter that never goes busy
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     wait_cnt <= '0;
      else if (state == WAIT_BUSY) wait_cnt <= wait_cnt + 2'd1;
      else                         wait_cnt <= '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_start <= 1'b0;
         tx_data  <= '0;
      end else begin
         tx_start <= start_nxt;
         if (pop_c) tx_data <= mem[rd_ptr[AW-1:0]];
      end
   end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Self-checking bench for uart_echo_fifo: a model transmitter feeds a scoreboard of
// expected echo bytes; table vectors cover case transforms, sequences cover the corners.
module tb_uart_echo_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_rcv;
   logic [7:0] rx_data;
   logic       tx_ready;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [1:0] mode;
   logic       ovf_clr;
   logic [3:0] leds;
   logic       ovf;
   logic [7:0] drop_cnt;
   logic [4:0] level;

   always #5 clk = ~clk;

   uart_echo_fifo #(.DW(8), .AW(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .rx_rcv(rx_rcv), .rx_data(rx_data),
      .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
      .mode(mode), .ovf_clr(ovf_clr), .leds(leds), .ovf(ovf),
      .drop_cnt(drop_cnt), .level(level)
   );

   int checks = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   // Model uart_tx: goes busy for tx_len cycles on tx_start unless deaf
   logic model_ready = 1'b1;
   logic tx_hold = 1'b0;
   logic deaf = 1'b0;
   int   tx_len = 6;
   int   busy_cnt = 0;
   int   starts = 0;
   longint start_t[$];
   assign tx_ready = tx_hold ? 1'b0 : model_ready;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) model_ready = 1'b1;
      end
      if (tx_start) begin
         starts++;
         start_t.push_back($time);
         if (exp_q.size() == 0) check("unexpected_tx_start", longint'(tx_data), -1);
         else                   check("tx_data", longint'(tx_data), longint'(exp_q.pop_front()));
         if (!deaf) begin
            model_ready = 1'b0;
            busy_cnt = tx_len;
         end
      end
   end

   longint send_t;
   task automatic send(input logic [7:0] d);
      @(negedge clk);
      rx_rcv = 1'b1;
      rx_data = d;
      send_t = $time;
      @(negedge clk);
      rx_rcv = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (!(exp_q.size() == 0 && level == 5'd0 && model_ready && busy_cnt == 0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(name, longint'(exp_q.size()), 0);
      repeat (3) @(negedge clk);
   endtask

   typedef struct {
      logic [1:0] mode;
      logic [7:0] din;
      logic [7:0] dout;
   } vec_t;
   vec_t vecs[8];

   initial begin
      int s0;
      vecs[0] = '{2'b01, 8'h61, 8'h41};  // 'a' -> 'A'
      vecs[1] = '{2'b01, 8'h5A, 8'h5A};  // 'Z' unchanged
      vecs[2] = '{2'b01, 8'h7B, 8'h7B};  // '{' just past 'z'
      vecs[3] = '{2'b01, 8'h60, 8'h60};  // '`' just before 'a'
      vecs[4] = '{2'b10, 8'h41, 8'h61};  // 'A' -> 'a'
      vecs[5] = '{2'b10, 8'h7A, 8'h7A};  // 'z' unchanged
      vecs[6] = '{2'b10, 8'h40, 8'h40};  // '@' just before 'A'
      vecs[7] = '{2'b10, 8'h5B, 8'h5B};  // '[' just past 'Z'

      rst = 1'b1; rx_rcv = 1'b0; rx_data = 8'h00; mode = 2'b00; ovf_clr = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_level", level, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_leds", leds, 0);
      check("rst_ovf", ovf, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      rst = 1'b0;

      // T1: single echo and latency
      exp_q.push_back(8'h41);
      send(8'h41);
      wait_drain("t1_drain");
      check("t1_latency", start_t[start_t.size()-1] - send_t, 30);
      check("t1_leds", leds, 4'h1);
      check("t1_level", level, 0);

      // T2: case transform table
      foreach (vecs[i]) begin
         mode = vecs[i].mode;
         exp_q.push_back(vecs[i].dout);
         send(vecs[i].din);
         wait_drain("t2_drain");
         check("t2_leds", leds, longint'(vecs[i].din[3:0]));
      end
      mode = 2'b00;

      // T3: overflow while transmitter is held busy
      tx_hold = 1'b1;
      for (int i = 0; i < 18; i++) begin
         if (i < 16) exp_q.push_back(8'h30 + 8'(i));
         send(8'h30 + 8'(i));
      end
      check("t3_level", level, 16);
      check("t3_ovf", ovf, 1);
      check("t3_drop_cnt", drop_cnt, 2);
      tx_hold = 1'b0;
      wait_drain("t3_drain");

      @(negedge clk); ovf_clr = 1'b1;
      @(negedge clk); ovf_clr = 1'b0;
      check("clr_ovf", ovf, 0);
      check("clr_drop_cnt", drop_cnt, 0);

      // T4: drop and pop in the same cycle on a full FIFO
      tx_hold = 1'b1;
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(8'h60 + 8'(i));
         send(8'h60 + 8'(i));
      end
      check("t4_full", level, 16);
      @(negedge clk); rx_rcv = 1'b1; rx_data = 8'hEE; tx_hold = 1'b0;
      @(negedge clk); rx_rcv = 1'b0; tx_hold = 1'b1;
      check("t4_level", level, 15);
      check("t4_drop_cnt", drop_cnt, 1);
      check("t4_ovf", ovf, 1);
      exp_q.push_back(8'h70);
      send(8'h70);
      check("t4_refull", level, 16);
      @(negedge clk); rx_rcv = 1'b1; rx_data = 8'hEF; ovf_clr = 1'b1;
      @(negedge clk); rx_rcv = 1'b0; ovf_clr = 1'b0;
      check("t4_clr_ovf", ovf, 0);
      check("t4_clr_drop_cnt", drop_cnt, 0);
      check("t4_clr_level", level, 16);
      tx_hold = 1'b0;
      wait_drain("t4_drain");

      // T5: mute mode, then a transmitter that never goes busy
      s0 = starts;
      mode = 2'b11;
      for (int i = 1; i <= 5; i++) send(8'h10 + 8'(i));
      repeat (10) @(negedge clk);
      check("t5_no_start", starts - s0, 0);
      check("t5_level", level, 0);
      check("t5_leds", leds, 4'h5);
      mode = 2'b00;
      deaf = 1'b1;
      s0 = starts;
      exp_q.push_back(8'h51);
      exp_q.push_back(8'h52);
      send(8'h51);
      send(8'h52);
      for (int n = 0; n < 100 && starts < s0 + 2; n++) @(negedge clk);
      check("t5_starts", starts - s0, 2);
      if (starts >= s0 + 2)
         check("t5_timeout_gap", start_t[s0+1] - start_t[s0], 60);
      deaf = 1'b0;
      wait_drain("t5_drain");

      // T6: reset during WAIT_DONE with bytes queued
      tx_len = 20;
      exp_q.push_back(8'hA0);
      for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i));
      check("t6_pre_level", level, 3);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      check("t6_level", level, 0);
      check("t6_tx_start", tx_start, 0);
      check("t6_ovf", ovf, 0);
      rst = 1'b0;
      tx_len = 6;
      exp_q.push_back(8'h42);
      send(8'h42);
      wait_drain("t6_drain");
      check("t6_leds", leds, 4'h2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
